// File: rtl/mem_arbiter_n.sv
// mem_arbiter_n: N-channel native-memory arbiter with per-transaction ownership lock.
// Selection is fixed priority or round robin; the chosen channel is muxed straight
// onto the memory port and the response is routed back only to that channel.
module mem_arbiter_n #(
    parameter int NUM_CH     = 2,
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int RR_MODE    = 0
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [NUM_CH-1:0]              req_valid,
    input  logic [NUM_CH-1:0]              req_instr,
    input  logic [NUM_CH*ADDR_WIDTH-1:0]   req_addr,
    input  logic [NUM_CH*DATA_WIDTH-1:0]   req_wdata,
    input  logic [NUM_CH*DATA_WIDTH/8-1:0] req_wstrb,
    output logic [NUM_CH*DATA_WIDTH-1:0]   rsp_rdata,
    output logic [NUM_CH-1:0]              rsp_ready,
    output logic                           memory_valid,
    output logic                           memory_instr,
    output logic [ADDR_WIDTH-1:0]          memory_addr,
    output logic [DATA_WIDTH-1:0]          memory_wdata,
    output logic [DATA_WIDTH/8-1:0]        memory_wstrb,
    input  logic [DATA_WIDTH-1:0]          memory_rdata,
    input  logic                           memory_ready,
    output logic [$clog2(NUM_CH)-1:0]      grant_id,
    output logic                           busy
);

    localparam int IDW  = $clog2(NUM_CH);
    localparam int STRB = DATA_WIDTH / 8;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t         r_state;
    logic [IDW-1:0] r_owner;
    logic [IDW-1:0] r_rrPtr;

    logic           w_locked;
    logic [IDW-1:0] w_base;
    logic [IDW-1:0] w_cand;
    logic [IDW-1:0] w_winner;
    logic           w_found;
    logic [IDW-1:0] w_sel;
    logic           w_memValid;

    // Channel index base+off, wrapping NUM_CH-1 -> 0 (off never exceeds NUM_CH-1).
    function automatic logic [IDW-1:0] wrapAdd(input logic [IDW-1:0] base, input int off);
        int s;
        s = int'(base) + off;
        if (s >= NUM_CH) begin
            s = s - NUM_CH;
        end
        return IDW'(s);
    endfunction

    assign w_locked = (r_state == BUSY);

    // Winner search: first valid channel scanning upward from the base, where the
    // base is the round-robin pointer in RR mode and channel 0 in fixed mode.
    always_comb begin
        w_base   = (RR_MODE != 0) ? r_rrPtr : '0;
        w_cand   = '0;
        w_winner = '0;
        w_found  = 1'b0;
        for (int k = 0; k < NUM_CH; k++) begin
            w_cand = wrapAdd(w_base, k);
            if (!w_found && req_valid[w_cand]) begin
                w_winner = w_cand;
                w_found  = 1'b1;
            end
        end
    end

    assign w_sel      = w_locked ? r_owner : w_winner;
    assign w_memValid = req_valid[w_sel];

    assign memory_valid = w_memValid;
    assign memory_instr = req_instr[w_sel];
    assign memory_addr  = req_addr[w_sel*ADDR_WIDTH +: ADDR_WIDTH];
    assign memory_wdata = req_wdata[w_sel*DATA_WIDTH +: DATA_WIDTH];
    assign memory_wstrb = req_wstrb[w_sel*STRB +: STRB];
    assign grant_id     = w_sel;
    assign busy         = w_locked;

    // Response routing: only the selected channel sees read data and completion.
    always_comb begin
        rsp_rdata = '0;
        rsp_ready = '0;
        rsp_ready[w_sel] = memory_ready & w_memValid;
        rsp_rdata[w_sel*DATA_WIDTH +: DATA_WIDTH] = memory_rdata;
    end

    // Lock FSM: take ownership on a stalled request, release on completion, and
    // advance the round-robin pointer only when a transaction actually completes.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= IDLE;
            r_owner <= '0;
            r_rrPtr <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_memValid) begin
                        if (!memory_ready) begin
                            r_owner <= w_sel;
                            r_state <= BUSY;
                        end else if (RR_MODE != 0) begin
                            r_rrPtr <= wrapAdd(w_sel, 1);
                        end
                    end
                end
                BUSY: begin
                    if (memory_ready) begin
                        r_state <= IDLE;
                        if (RR_MODE != 0) begin
                            r_rrPtr <= wrapAdd(r_owner, 1);
                        end
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/mem_arbiter_n.md
Name: mem_arbiter_n

Overview:
- N-channel successor to the two-port instruction/data memory arbiter.
- Multiplexes N native-memory requesters (valid/instr/addr/wdata/wstrb, rdata/ready) onto one memory port.
- Arbitration is selectable: fixed priority or round robin.
- Ownership is locked per transaction until memory_ready, so a response is never misrouted. Sits between core/DMA masters and the memory/bus bridge.

Parameters:
- NUM_CH, 2, number of requesters (2..8).
- ADDR_WIDTH, 32, address width.
- DATA_WIDTH, 32, data width; strobe width is DATA_WIDTH/8.
- RR_MODE, 0, 0 = fixed priority (index 0 highest), 1 = round robin.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous active-low reset.
- req_valid  in  NUM_CH  per-channel request valid.
- req_instr  in  NUM_CH  per-channel instruction-fetch flag.
- req_addr  in  NUM_CH*ADDR_WIDTH  per-channel address, channel i at [i*ADDR_WIDTH +: ADDR_WIDTH].
- req_wdata  in  NUM_CH*DATA_WIDTH  per-channel write data.
- req_wstrb  in  NUM_CH*DATA_WIDTH/8  per-channel write strobes (0 = read).
- rsp_rdata  out  NUM_CH*DATA_WIDTH  per-channel read data.
- rsp_ready  out  NUM_CH  per-channel completion.
- memory_valid  out  1  downstream request valid.
- memory_instr  out  1  downstream fetch flag.
- memory_addr  out  ADDR_WIDTH  downstream address.
- memory_wdata  out  DATA_WIDTH  downstream write data.
- memory_wstrb  out  DATA_WIDTH/8  downstream strobes.
- memory_rdata  in  DATA_WIDTH  downstream read data.
- memory_ready  in  1  downstream completion.
- grant_id  out  $clog2(NUM_CH)  current selected channel (debug).
- busy  out  1  transaction locked.

Behaviour:
- Reset (rst=0, async): locked=0, owner=0, rr_ptr=0. Outputs are then busy=0 and grant_id=winner of the current req_valid (0 if none); rsp_ready all 0 unless memory_ready; memory_* follow the comb rules below.
- Requester protocol: hold valid and all fields stable from assertion until its rsp_ready cycle.
  - Dropping valid while owner is a protocol violation. The arbiter keeps the lock until memory_ready regardless.
- Selection (comb):
  - sel = owner when locked, else winner.
  - Fixed mode: winner = lowest-index valid channel.
  - RR mode: winner = first valid channel at or after rr_ptr, with wrap NUM_CH-1 -> 0.
  - No valid requests: winner = 0.
- Downstream mux (comb, zero added latency): memory_* = channel sel fields. memory_valid = req_valid[sel] (0 when nothing valid and unlocked).
- Response routing (comb):
  - rsp_ready[sel] = memory_ready & memory_valid; rsp_rdata of channel sel = memory_rdata.
  - All other channels: rsp_ready=0, rsp_rdata=0.
- FSM states:
  - IDLE (locked=0):
    - memory_valid=1 and memory_ready=0: owner<=sel, locked<=1, go BUSY.
    - memory_valid=1 and memory_ready=1 (single-cycle memory): stay IDLE; in RR mode rr_ptr<=sel+1 (wrap).
  - BUSY (locked=1):
    - Selection frozen on owner; requests from other channels are ignored.
    - On memory_ready: locked<=0, go IDLE; in RR mode rr_ptr<=owner+1 (wrap).
    - The next transaction can start the cycle after completion, with no idle bubble beyond the re-arbitration.
- busy = locked; grant_id = sel.
- Simultaneous events: a new higher-priority request arriving during BUSY waits. The completion cycle and new requests in that cycle do not change the completing owner's routing.
- Reset mid-transaction: lock drops immediately. The in-flight downstream access is abandoned and the memory side must itself be reset by the same rst.
- rr_ptr updates only on completed transactions, never on idle cycles.

Test Plan:
- Fixed mode, NUM_CH=2: ch0 and ch1 valid together, memory_ready after 2 wait cycles.
  - Required: ch0 addr 0x100 on memory_addr; rsp_ready[0]=1 at cycle 3 with rdata 0xDEADBEEF.
  - Then ch1 addr 0x200 is granted the following cycle.
- RR mode, NUM_CH=4: all 4 channels valid continuously, single-cycle memory.
  - Required: grant order 0,1,2,3,0; each channel receives exactly one rsp_ready per 4 cycles.
- Lock hold: ch1 owner in BUSY for 5 cycles, ch0 raises valid in cycle 2.
  - Required: memory_addr stays at ch1 value; rsp_ready[0]=0 until ch1 completes; ch0 is granted next.
- Write path: ch2 wstrb=0xF, wdata 0x12345678.
  - Required: memory_wstrb=0xF and memory_wdata=0x12345678.
  - rsp_rdata of ch0, ch1 and ch3 stays 0 throughout.
- Async reset: assert rst=0 mid-BUSY, between clock edges.
  - Required: busy=0 immediately without a clock edge; after release, RR pointer restarts at 0.
- Idle: no req_valid for 10 cycles -> memory_valid=0, rr_ptr unchanged, grant_id=0.
